// File: rtl/qeciphy_tx_link_sequencer.sv
// TX link bring-up sequencer: drives the encoder's link_enable/data_enable pair
// through IDLE -> WAIT_TX -> TRAIN -> ACTIVE, with BACKOFF/retry on failure.
module qeciphy_tx_link_sequencer #(
   parameter int TRAIN_CYCLES = 1024,
   parameter int RX_TIMEOUT   = 65536,
   parameter int BACKOFF      = 256
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       link_req_i,
   input  logic       tx_ready_i,
   input  logic       rx_rdy_i,
   input  logic       rx_error_i,
   output logic       link_enable_o,
   output logic       data_enable_o,
   output logic       link_up_o,
   output logic       timeout_o,
   output logic [7:0] retry_cnt_o,
   output logic [2:0] state_o
);

   localparam int CNT_MAX = (RX_TIMEOUT > BACKOFF) ? RX_TIMEOUT : BACKOFF;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] TRAIN_LAST   = CNT_W'(TRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(RX_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] BACKOFF_LAST = CNT_W'(BACKOFF - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT_TX = 3'd1,
      ST_TRAIN   = 3'd2,
      ST_ACTIVE  = 3'd3,
      ST_BACKOFF = 3'd4
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_retry;
   logic             r_link_en;
   logic             r_data_en;
   logic             r_link_up;
   logic             r_timeout;

   state_t           w_state_next;
   logic             w_timeout_next;
   logic             w_counting;

   always_comb begin
      w_state_next   = r_state;
      w_timeout_next = 1'b0;
      if (!link_req_i) begin
         w_state_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:    w_state_next = ST_WAIT_TX;
            ST_WAIT_TX: if (tx_ready_i) w_state_next = ST_TRAIN;
            ST_TRAIN: begin
               // A ready RX at the end of training beats a coincident timeout.
               if (!tx_ready_i) begin
                  w_state_next = ST_BACKOFF;
               end else if ((r_cnt >= TRAIN_LAST) && rx_rdy_i) begin
                  w_state_next = ST_ACTIVE;
               end else if (r_cnt == TIMEOUT_LAST) begin
                  w_state_next   = ST_BACKOFF;
                  w_timeout_next = 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (!tx_ready_i || !rx_rdy_i || rx_error_i) w_state_next = ST_BACKOFF;
            end
            ST_BACKOFF: if (r_cnt == BACKOFF_LAST) w_state_next = ST_WAIT_TX;
            default:    w_state_next = ST_IDLE;
         endcase
      end
   end

   assign w_counting = (w_state_next == r_state) &&
                       ((r_state == ST_TRAIN) || (r_state == ST_BACKOFF));

   // Outputs are registered from the next state so they always match state_o.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_retry   <= 8'd0;
         r_link_en <= 1'b0;
         r_data_en <= 1'b0;
         r_link_up <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_counting ? (r_cnt + CNT_W'(1)) : '0;
         if ((w_state_next == ST_BACKOFF) && (r_state != ST_BACKOFF) && (r_retry != 8'hFF)) begin
            r_retry <= r_retry + 8'd1;
         end
         r_link_en <= (w_state_next == ST_TRAIN) || (w_state_next == ST_ACTIVE);
         r_data_en <= (w_state_next == ST_ACTIVE);
         r_link_up <= (w_state_next == ST_ACTIVE);
         r_timeout <= w_timeout_next;
      end
   end

   assign link_enable_o = r_link_en;
   assign data_enable_o = r_data_en;
   assign link_up_o     = r_link_up;
   assign timeout_o     = r_timeout;
   assign retry_cnt_o   = r_retry;
   assign state_o       = r_state;

endmodule

// File: tb/tb_qeciphy_tx_link_sequencer.sv
// Bench for qeciphy_tx_link_sequencer: phase/dwell model checked every cycle,
// plus directed scenarios with hand-computed timings and counts.
module tb_qeciphy_tx_link_sequencer;

   localparam int TRAIN_CYCLES = 16;
   localparam int RX_TIMEOUT   = 64;
   localparam int BACKOFF      = 8;

   localparam int P_IDLE = 0, P_WAIT = 1, P_TRAIN = 2, P_ACTIVE = 3, P_BACKOFF = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req = 1'b0, tx = 1'b0, rx = 1'b0, err = 1'b0;
   logic       link_en, data_en, link_up, tmo;
   logic [7:0] retry;
   logic [2:0] state;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   qeciphy_tx_link_sequencer #(
      .TRAIN_CYCLES(TRAIN_CYCLES),
      .RX_TIMEOUT  (RX_TIMEOUT),
      .BACKOFF     (BACKOFF)
   ) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .link_req_i   (req),
      .tx_ready_i   (tx),
      .rx_rdy_i     (rx),
      .rx_error_i   (err),
      .link_enable_o(link_en),
      .data_enable_o(data_en),
      .link_up_o    (link_up),
      .timeout_o    (tmo),
      .retry_cnt_o  (retry),
      .state_o      (state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Model: which phase we are in, how many whole cycles have been spent there,
   // how many times a backoff was started, and whether a timeout just fired.
   typedef struct packed {
      int phase;
      int dwell;
      int retries;
      bit tmo;
   } model_t;

   model_t m = '0;

   function automatic model_t enter(model_t cur, int ph, bit by_timeout);
      model_t n = cur;
      n.phase = ph;
      n.dwell = 0;
      n.tmo   = by_timeout;
      if (ph == P_BACKOFF) n.retries = (cur.retries < 255) ? cur.retries + 1 : 255;
      return n;
   endfunction

   function automatic model_t model_step(model_t cur, bit r, bit t, bit x, bit e);
      model_t n = cur;
      int served = cur.dwell + 1;
      n.tmo = 1'b0;
      if (!r) begin
         n.phase = P_IDLE;
         n.dwell = 0;
         return n;
      end
      case (cur.phase)
         P_IDLE: n = enter(n, P_WAIT, 1'b0);
         P_WAIT: if (t) n = enter(n, P_TRAIN, 1'b0);
         P_TRAIN: begin
            if (!t)                                n = enter(n, P_BACKOFF, 1'b0);
            else if (served >= TRAIN_CYCLES && x)  n = enter(n, P_ACTIVE, 1'b0);
            else if (served == RX_TIMEOUT)         n = enter(n, P_BACKOFF, 1'b1);
            else                                   n.dwell = served;
         end
         P_ACTIVE: if (!t || !x || e) n = enter(n, P_BACKOFF, 1'b0);
         P_BACKOFF: begin
            if (served == BACKOFF) n = enter(n, P_WAIT, 1'b0);
            else                   n.dwell = served;
         end
         default: n = enter(n, P_IDLE, 1'b0);
      endcase
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '0;
      else        m <= model_step(m, req, tx, rx, err);
   end

   // Per-cycle compare against the model plus enable-ordering invariants.
   logic prev_link = 1'b0, prev_data = 1'b0;
   int   shown = 0;
   always @(negedge clk) begin
      logic [15:0] act, exp;
      act = {state, link_en, data_en, link_up, tmo, retry};
      exp = {m.phase[2:0],
             (m.phase == P_TRAIN) || (m.phase == P_ACTIVE),
             m.phase == P_ACTIVE,
             m.phase == P_ACTIVE,
             m.tmo,
             m.retries[7:0]};
      checks++;
      if (act !== exp) begin
         errors++;
         if (shown < 20) $display("FAIL model cyc %0d: got %h expected %h", cyc, act, exp);
         shown++;
      end
      checks++;
      if (data_en && !link_en) begin
         errors++;
         $display("FAIL data_without_link cyc %0d: got data=%b link=%b", cyc, data_en, link_en);
      end
      checks++;
      if (data_en && !prev_data && !prev_link) begin
         errors++;
         $display("FAIL data_rise_with_link cyc %0d: data rose with link previously %b", cyc, prev_link);
      end
      prev_link = link_en;
      prev_data = data_en;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_state(input int s, input int budget, input string name, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (state == 3'(s)) begin
            at = cyc;
            break;
         end
      end
      checks++;
      if (at < 0) begin
         errors++;
         $display("FAIL %s: got no state %0d within %0d cycles expected state %0d", name, s, budget, s);
      end
   endtask

   initial begin
      int t_train, t_active, t_back, t_wait, n_tmo;

      repeat (3) @(negedge clk);
      check("reset_outputs", int'({state, link_en, data_en, link_up, tmo, retry}), 0);
      rst_n = 1'b1;

      // Bring-up: request, TX ready two cycles later, RX ready while training.
      req = 1'b1;
      repeat (2) @(negedge clk);
      check("wait_tx_state", int'(state), P_WAIT);
      tx = 1'b1;
      wait_state(P_TRAIN, 10, "reach_train", t_train);
      check("train_link_en", int'({link_en, data_en}), 2);
      repeat (3) @(negedge clk);
      rx = 1'b1;
      wait_state(P_ACTIVE, 100, "reach_active", t_active);
      check("train_length", t_active - t_train, 16);
      check("active_outputs", int'({link_en, data_en, link_up}), 7);
      check("bringup_retry", int'(retry), 0);

      // Request removal in ACTIVE.
      repeat (5) @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      check("drop_active_idle", int'({state, link_en, data_en, link_up}), 0);
      check("drop_active_retry", int'(retry), 0);

      // Timeout: RX never ready.
      rx = 1'b0;
      req = 1'b1;
      wait_state(P_TRAIN, 10, "timeout_train", t_train);
      wait_state(P_BACKOFF, 200, "timeout_backoff", t_back);
      check("timeout_train_len", t_back - t_train, 64);
      check("timeout_pulse", int'(tmo), 1);
      check("timeout_retry", int'(retry), 1);
      check("backoff_enables", int'({link_en, data_en}), 0);
      @(negedge clk);
      check("timeout_pulse_end", int'(tmo), 0);
      wait_state(P_WAIT, 50, "backoff_exit", t_wait);
      check("backoff_len", t_wait - t_back, 8);
      rx = 1'b1;
      wait_state(P_ACTIVE, 100, "retry_active", t_active);

      // One-cycle rx_error in ACTIVE.
      err = 1'b1;
      @(negedge clk);
      err = 1'b0;
      check("error_backoff", int'({state, link_en, data_en}), 8'(P_BACKOFF << 2));
      check("error_retry", int'(retry), 2);

      // Request removal in BACKOFF, then in TRAIN.
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      check("drop_backoff_idle", int'({state, link_en, data_en, link_up, tmo}), 0);
      check("drop_backoff_retry", int'(retry), 2);
      rx = 1'b0;
      req = 1'b1;
      wait_state(P_TRAIN, 10, "train_again", t_train);
      repeat (5) @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      check("drop_train_idle", int'({state, link_en, data_en, link_up, tmo}), 0);
      check("drop_train_retry", int'(retry), 2);

      // Saturation: 300 consecutive timeouts.
      req = 1'b1;
      n_tmo = 0;
      for (int i = 0; i < 25000 && n_tmo < 300; i++) begin
         @(negedge clk);
         if (tmo) n_tmo++;
      end
      check("timeout_count", n_tmo, 300);
      check("retry_saturated", int'(retry), 255);

      // Async reset in the middle of ACTIVE.
      rx = 1'b1;
      wait_state(P_ACTIVE, 200, "sat_active", t_active);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs", int'({state, link_en, data_en, link_up, tmo, retry}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_state(P_ACTIVE, 100, "restart_active", t_active);
      check("restart_retry", int'(retry), 0);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
